// File: rtl/viterbi_out_checker_if.sv
// Bundles the checker's stream inputs and status outputs.
//   X         : encoder input symbol (2 bits)
//   Out       : decoder output; [1:0] decoded symbol, [2] unused by the checker
//   Dec_err   : decoder error flag; marks the current sample invalid
//   Locked    : checker is in LOCKED
//   Mismatch  : one-cycle pulse per counted mismatch while locked
//   Err_count : saturating mismatch count while locked
//   Cmp_count : saturating valid-comparison count while locked
// master = stimulus side (decoder/encoder environment), slave = checker.
interface viterbi_out_checker_if;
    logic [1:0]  X;
    logic [2:0]  Out;
    logic        Dec_err;
    logic        Locked;
    logic        Mismatch;
    logic [7:0]  Err_count;
    logic [15:0] Cmp_count;

    modport master (
        output X, Out, Dec_err,
        input  Locked, Mismatch, Err_count, Cmp_count
    );

    modport slave (
        input  X, Out, Dec_err,
        output Locked, Mismatch, Err_count, Cmp_count
    );
endinterface

// File: rtl/viterbi_out_checker.sv
// Compares a Viterbi decoder's output against the encoder input delayed by
// the decoder latency, acquires lock after a run of matches and tracks
// mismatches while locked.
//   Clk : clock, all state on rising edge
//   Res : synchronous active-high reset
//   bus : viterbi_out_checker_if.slave (X, Out, Dec_err in; Locked,
//         Mismatch, Err_count, Cmp_count out, all registered)
module viterbi_out_checker #(
    parameter int unsigned LATENCY  = 12,
    parameter int unsigned LOCK_RUN = 4,
    parameter int unsigned LOSS_RUN = 3
) (
    input  logic                  Clk,
    input  logic                  Res,
    viterbi_out_checker_if.slave  bus
);

    localparam int unsigned DEPTH   = 31;
    localparam int unsigned REF_IDX = LATENCY - 1;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         fill_q, fill_d;
    logic [3:0]         run_q, run_d;
    logic [3:0]         loss_q, loss_d;
    logic [7:0]         err_q, err_d;
    logic [15:0]        cmp_q, cmp_d;
    logic               mis_q, mis_d;
    logic               locked_q, locked_d;

    logic [DEPTH-1:0][1:0] sr_q;
    logic [1:0]         xref;
    logic               valid;
    logic               match;
    logic               unused_out_msb;

    assign unused_out_msb = bus.Out[2];

    // Delay line of X; shifts every edge regardless of state or Dec_err.
    // Entry k holds X from k+1 edges ago, so entry LATENCY-1 is the reference.
    always_ff @(posedge Clk) begin
        sr_q <= {sr_q[DEPTH-2:0], bus.X};
    end

    assign xref  = sr_q[REF_IDX];
    assign valid = ~bus.Dec_err;
    assign match = (bus.Out[1:0] == xref);

    // State and counter registers; reset overrides everything.
    always_ff @(posedge Clk) begin
        if (Res) begin
            state_q  <= FILL;
            fill_q   <= '0;
            run_q    <= '0;
            loss_q   <= '0;
            err_q    <= '0;
            cmp_q    <= '0;
            mis_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            run_q    <= run_d;
            loss_q   <= loss_d;
            err_q    <= err_d;
            cmp_q    <= cmp_d;
            mis_q    <= mis_d;
            locked_q <= locked_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        run_d    = run_q;
        loss_d   = loss_q;
        err_d    = err_q;
        cmp_d    = cmp_q;
        mis_d    = 1'b0;

        case (state_q)
            // Edge count tracks delay-line occupancy, so Dec_err does not stall it.
            FILL: begin
                if (fill_q == 5'(REF_IDX)) begin
                    state_d = ACQUIRE;
                    fill_d  = '0;
                end else begin
                    fill_d = fill_q + 5'd1;
                end
            end

            ACQUIRE: begin
                if (valid) begin
                    if (match) begin
                        if (run_q == 4'(LOCK_RUN - 1)) begin
                            state_d = LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
            end

            LOCKED: begin
                if (valid) begin
                    cmp_d = (cmp_q == 16'hFFFF) ? cmp_q : cmp_q + 16'd1;
                    if (match) begin
                        loss_d = '0;
                    end else begin
                        mis_d = 1'b1;
                        err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                        if (loss_q == 4'(LOSS_RUN - 1)) begin
                            state_d = ACQUIRE;
                            loss_d  = '0;
                            run_d   = '0;
                        end else begin
                            loss_d = loss_q + 4'd1;
                        end
                    end
                end
            end

            default: begin
                state_d = FILL;
                fill_d  = '0;
                run_d   = '0;
                loss_d  = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    assign bus.Locked    = locked_q;
    assign bus.Mismatch  = mis_q;
    assign bus.Err_count = err_q;
    assign bus.Cmp_count = cmp_q;

endmodule
